// File: rtl/keycode_event_queue.sv
// Keycode change-event FIFO with an Avalon-MM slave: synchronises the raw keycode,
// queues every change as an event, and raises a level interrupt while events or an overflow are pending.
module keycode_event_queue #(
    parameter int KEY_W = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [KEY_W-1:0] in_port,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_STATUS  = 2'd1,
        ADDR_CONTROL = 2'd2,
        ADDR_CURRENT = 2'd3
    } addr_e;

    logic [KEY_W-1:0] sync_q, sync_d;
    logic [KEY_W-1:0] key_s_q, key_s_d;
    logic [KEY_W-1:0] key_prev_q, key_prev_d;
    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [KEY_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             enable_q, enable_d;
    logic             irq_en_q, irq_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    addr_e addr;
    logic  rd_en, wr_en, empty, full, change;
    logic  pop, push_req, push, flush, ovf_set, ovf_clr;
    logic  unused_wdata;

    always_comb begin
        unused_wdata = ^{writedata[30:17], writedata[15:2]};
    end

    always_comb begin
        addr     = addr_e'(address);
        rd_en    = chipselect & read;
        wr_en    = chipselect & write;
        empty    = (count_q == '0);
        full     = (count_q == (PW+1)'(DEPTH));
        change   = (key_s_q != key_prev_q);
        pop      = rd_en && (addr == ADDR_DATA) && !empty;
        flush    = wr_en && (addr == ADDR_STATUS) && writedata[31];
        ovf_clr  = wr_en && (addr == ADDR_STATUS) && writedata[16];
        // A flush swallows the event of its cycle without flagging overflow.
        push_req = change && enable_q && !flush;
        push     = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;

        sync_d     = in_port;
        key_s_d    = sync_q;
        key_prev_d = key_s_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;

        if (push) begin
            mem_d[wr_ptr_q] = key_s_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        ovf_d = (ovf_q && !ovf_clr) || ovf_set;

        if (wr_en && (addr == ADDR_CONTROL)) begin
            enable_d = writedata[0];
            irq_en_d = writedata[1];
        end

        irq_d = irq_en_d && ((count_d != '0) || ovf_d);
    end

    always_comb begin
        readdata_d = '0;
        if (rd_en) begin
            case (addr)
                ADDR_DATA: begin
                    if (!empty) begin
                        readdata_d[KEY_W-1:0] = mem_q[rd_ptr_q];
                        readdata_d[KEY_W]     = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    readdata_d[PW:0] = count_q;
                    readdata_d[16]   = ovf_q;
                    readdata_d[17]   = empty;
                    readdata_d[18]   = full;
                end
                ADDR_CONTROL: begin
                    readdata_d[0] = enable_q;
                    readdata_d[1] = irq_en_q;
                end
                ADDR_CURRENT: begin
                    readdata_d[KEY_W-1:0] = key_s_q;
                end
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            key_s_q    <= '0;
            key_prev_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            enable_q   <= 1'b1;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            key_s_q    <= key_s_d;
            key_prev_q <= key_prev_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        readdata = readdata_q;
        irq      = irq_q;
    end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: fixed vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_keycode_event_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_port;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    keycode_event_queue #(.KEY_W(8), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: three-stage view of the keycode, an event queue and the control bits.
    logic [7:0]  m_s1, m_ks, m_kp;
    logic [7:0]  m_q[$];
    logic        m_ovf, m_en, m_ien;
    logic [31:0] m_rd;
    logic        m_irq;

    logic [7:0]  cur_key;
    logic [31:0] last_rd;

    typedef struct {
        logic [7:0]  k;
        logic        c, r, w;
        logic [1:0]  a;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t t1[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_s1 = '0; m_ks = '0; m_kp = '0;
        m_q.delete();
        m_ovf = 1'b0; m_en = 1'b1; m_ien = 1'b0;
        m_rd = '0; m_irq = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] k, input logic c, r, w,
                                       input logic [1:0] a, input logic [31:0] wd);
        bit do_pop;
        bit pushing;
        pushing = (m_ks != m_kp) && m_en;
        do_pop  = 1'b0;
        m_rd    = '0;
        if (c && r) begin
            case (a)
                2'd0: if (m_q.size() > 0) begin
                    m_rd   = 32'h100 | 32'(m_q[0]);
                    do_pop = 1'b1;
                end
                2'd1: m_rd = {13'b0, m_q.size() == DEPTH, m_q.size() == 0, m_ovf, 16'(m_q.size())};
                2'd2: m_rd = {30'b0, m_ien, m_en};
                default: m_rd = {24'b0, m_ks};
            endcase
        end
        if (do_pop) void'(m_q.pop_front());
        if (c && w && a == 2'd1 && wd[16]) m_ovf = 1'b0;
        if (c && w && a == 2'd1 && wd[31]) begin
            m_q.delete();
        end else if (pushing) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_ks);
            else m_ovf = 1'b1;
        end
        if (c && w && a == 2'd2) begin
            m_en  = wd[0];
            m_ien = wd[1];
        end
        m_kp  = m_ks;
        m_ks  = m_s1;
        m_s1  = k;
        m_irq = m_ien && (m_q.size() > 0 || m_ovf);
    endfunction

    // One clock: inputs driven just after an edge, effect checked just after the next.
    task automatic tick(input logic [7:0] k, input logic c, r, w,
                        input logic [1:0] a, input logic [31:0] wd);
        in_port = k; chipselect = c; read = r; write = w; address = a; writedata = wd;
        @(posedge clk);
        model_step(k, c, r, w, a, wd);
        #1;
        check("readdata", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        last_rd = readdata;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic idle();
        tick(cur_key, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        tick(cur_key, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        tick(cur_key, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic send_key(input logic [7:0] k);
        cur_key = k;
        repeat (3) idle();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_port = '0; chipselect = 1'b0; address = '0;
        read = 1'b0; write = 1'b0; writedata = '0; cur_key = '0; last_rd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // T1: press and release of one key
        t1[0]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0};
        t1[1]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0};
        t1[2]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0};
        t1[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0};
        t1[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0};
        t1[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0};
        t1[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h0000_0002};
        t1[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0000_011A};
        t1[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0000_0100};
        t1[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0000_0000};
        t1[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h0002_0000};
        for (int i = 0; i < 11; i++) begin
            tick(t1[i].k, t1[i].c, t1[i].r, t1[i].w, t1[i].a, t1[i].wd);
            if (t1[i].chk) check("t1_vector", last_rd, t1[i].exp);
        end
        cur_key = 8'h00;

        // T2: overflow, in-order drain, OVF clear
        for (int i = 0; i < DEPTH + 3; i++) send_key(8'(8'h10 + i));
        rd_reg(2'd1);
        check("t2_status_full_ovf", last_rd, 32'h0005_0000 | DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg(2'd0);
            check("t2_pop_order", last_rd, 32'h100 | 32'(8'h10 + i));
        end
        wr_reg(2'd1, 32'h0001_0000);
        rd_reg(2'd1);
        check("t2_ovf_cleared", last_rd, 32'h0002_0000);

        // T3: push and pop in the same cycle while full
        for (int i = 0; i < DEPTH; i++) send_key(8'(8'h20 + i));
        cur_key = 8'h55;
        idle();
        idle();
        rd_reg(2'd0);
        check("t3_simul_pop", last_rd, 32'h0000_0120);
        rd_reg(2'd1);
        check("t3_status_full_no_ovf", last_rd, 32'h0004_0000 | DEPTH);
        for (int i = 1; i < DEPTH; i++) begin
            rd_reg(2'd0);
            check("t3_pop_order", last_rd, 32'h100 | 32'(8'h20 + i));
        end
        rd_reg(2'd0);
        check("t3_last_pop_new_code", last_rd, 32'h0000_0155);
        rd_reg(2'd0);
        check("t3_pop_empty", last_rd, 32'h0);

        // T4: interrupt from pending events and from overflow
        wr_reg(2'd2, 32'h3);
        send_key(8'h66);
        check("t4_irq_pending", {31'b0, irq}, 32'h1);
        rd_reg(2'd0);
        idle();
        check("t4_irq_after_pop", {31'b0, irq}, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) send_key(8'(8'h70 + i));
        wr_reg(2'd1, 32'h8000_0000);
        rd_reg(2'd1);
        check("t4_status_flushed_ovf", last_rd, 32'h0003_0000);
        check("t4_irq_ovf_empty", {31'b0, irq}, 32'h1);
        wr_reg(2'd1, 32'h0001_0000);
        check("t4_irq_cleared", {31'b0, irq}, 32'h0);

        // T5: disabled capture, then re-enable with a steady key
        wr_reg(2'd2, 32'h0);
        send_key(8'h00);
        send_key(8'h2C);
        idle();
        rd_reg(2'd1);
        check("t5_status_disabled", last_rd, 32'h0002_0000);
        rd_reg(2'd3);
        check("t5_current", last_rd, 32'h0000_002C);
        wr_reg(2'd2, 32'h1);
        repeat (4) idle();
        rd_reg(2'd1);
        check("t5_status_reenabled", last_rd, 32'h0002_0000);

        // T6: reset in the middle of a read
        wr_reg(2'd2, 32'h3);
        send_key(8'h31);
        send_key(8'h32);
        send_key(8'h33);
        rd_reg(2'd0);
        check("t6_pre_reset_pop", last_rd, 32'h0000_0131);
        cur_key = 8'h00;
        in_port = 8'h00; chipselect = 1'b1; read = 1'b1; address = 2'd0;
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_reset_readdata", readdata, 32'h0);
        check("t6_reset_irq", {31'b0, irq}, 32'h0);
        chipselect = 1'b0; read = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd_reg(2'd1);
        check("t6_status_after_reset", last_rd, 32'h0002_0000);
        rd_reg(2'd2);
        check("t6_control_after_reset", last_rd, 32'h0000_0001);

        // Randomized traffic against the model
        wr_reg(2'd2, 32'h3);
        for (int n = 0; n < 800; n++) begin
            int unsigned op;
            logic [31:0] wd;
            if ($urandom_range(0, 3) == 0)
                cur_key = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            op = $urandom_range(0, 9);
            wd = $urandom;
            if (op <= 3) begin
                idle();
            end else if (op <= 6) begin
                rd_reg((op == 6) ? 2'($urandom) : 2'd0);
            end else if (op == 7) begin
                wd[0] = ($urandom_range(0, 4) != 0);
                wr_reg(2'd2, wd);
            end else if (op == 8) begin
                wd[31] = ($urandom_range(0, 7) == 0);
                wr_reg(2'd1, wd);
            end else begin
                wr_reg(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, wd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
